// File: rtl/fb_write_scheduler.sv
// Serialises rasterizer pixels and a full-screen clear into read-modify-write
// operations on the packed 4bpp frame buffer's GPU port.
module fb_write_scheduler #(
  parameter int H_RES        = 320,
  parameter int V_RES        = 240,
  parameter int READ_LATENCY = 2
) (
  input  logic       gpu_clk,
  input  logic       reset_n,
  input  logic       px_valid,
  output logic       px_ready,
  input  logic [9:0] px_x,
  input  logic [9:0] px_y,
  input  logic [3:0] px_color,
  input  logic       clear_start,
  input  logic [3:0] clear_color,
  output logic       clear_busy,
  output logic       clear_done,
  output logic       gpu_access,
  output logic [9:0] gpu_x,
  output logic [9:0] gpu_y,
  output logic [3:0] gpu_data,
  output logic       gpu_we,
  output logic       idle
);

  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);
  localparam logic [9:0] X_LIM  = 10'(H_RES);
  localparam logic [9:0] Y_LIM  = 10'(V_RES);
  localparam logic [9:0] X_LAST = 10'(H_RES - 1);
  localparam logic [9:0] Y_LAST = 10'(V_RES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WRITE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [LAT_W-1:0] lat_q;
  logic             op_clr_q;
  logic             clear_busy_q;
  logic             clear_done_q;
  logic [3:0]       clear_color_q;
  logic [9:0]       cx_q;
  logic [9:0]       cy_q;
  logic             gpu_access_q;
  logic             gpu_we_q;
  logic [9:0]       gpu_x_q;
  logic [9:0]       gpu_y_q;
  logic [3:0]       gpu_data_q;

  // Clear requests block the rasterizer in the very cycle they arrive.
  assign px_ready   = (state_q == S_IDLE) && !clear_busy_q && !clear_start;
  assign idle       = (state_q == S_IDLE) && !clear_busy_q;
  assign clear_busy = clear_busy_q;
  assign clear_done = clear_done_q;
  assign gpu_access = gpu_access_q;
  assign gpu_we     = gpu_we_q;
  assign gpu_x      = gpu_x_q;
  assign gpu_y      = gpu_y_q;
  assign gpu_data   = gpu_data_q;

  always_ff @(posedge gpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      lat_q         <= '0;
      op_clr_q      <= 1'b0;
      clear_busy_q  <= 1'b0;
      clear_done_q  <= 1'b0;
      clear_color_q <= 4'd0;
      cx_q          <= 10'd0;
      cy_q          <= 10'd0;
      gpu_access_q  <= 1'b0;
      gpu_we_q      <= 1'b0;
      gpu_x_q       <= 10'd0;
      gpu_y_q       <= 10'd0;
      gpu_data_q    <= 4'd0;
    end else begin
      clear_done_q <= 1'b0;

      if (clear_start && !clear_busy_q) begin
        clear_busy_q  <= 1'b1;
        clear_color_q <= clear_color;
        cx_q          <= 10'd0;
        cy_q          <= 10'd0;
      end

      case (state_q)
        S_IDLE: begin
          if (clear_busy_q) begin
            op_clr_q     <= 1'b1;
            gpu_x_q      <= cx_q;
            gpu_y_q      <= cy_q;
            gpu_data_q   <= clear_color_q;
            gpu_access_q <= 1'b1;
            lat_q        <= '0;
            state_q      <= S_ACCESS;
          end else if (px_valid && px_ready) begin
            op_clr_q   <= 1'b0;
            gpu_x_q    <= px_x;
            gpu_y_q    <= px_y;
            gpu_data_q <= px_color;
            // Off-screen pixels are consumed without touching the buffer.
            if ((px_x < X_LIM) && (px_y < Y_LIM)) begin
              gpu_access_q <= 1'b1;
              lat_q        <= '0;
              state_q      <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (lat_q == LAT_LAST) begin
            gpu_we_q <= 1'b1;
            state_q  <= S_WRITE;
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        S_WRITE: begin
          gpu_we_q     <= 1'b0;
          gpu_access_q <= 1'b0;
          state_q      <= S_IDLE;
          if (op_clr_q) begin
            if (cx_q == X_LAST) begin
              cx_q <= 10'd0;
              if (cy_q == Y_LAST) begin
                cy_q         <= 10'd0;
                clear_busy_q <= 1'b0;
                clear_done_q <= 1'b1;
              end else begin
                cy_q <= cy_q + 10'd1;
              end
            end else begin
              cx_q <= cx_q + 10'd1;
            end
          end
        end
        default: begin
          gpu_we_q     <= 1'b0;
          gpu_access_q <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

endmodule
